// File: rtl/scanner_pkg.sv
// Shared state encoding and default sizing for the scan buffer controller.
// Pure declarations: no logic, no latency, no flow control.
package scanner_pkg;

    typedef enum logic [2:0] {
        ST_LOW_POWER = 3'd0,
        ST_STANDBY   = 3'd1,
        ST_SCANNING  = 3'd2,
        ST_IDLE      = 3'd3,
        ST_XFERRING  = 3'd4,
        ST_FLUSHING  = 3'd5
    } state_e;

    localparam int DEF_DEPTH       = 10;
    localparam int DEF_FILL_STEP   = 1;
    localparam int DEF_DRAIN_STEP  = 1;
    localparam int DEF_FLUSH_STEP  = 2;
    localparam int DEF_STANDBY_LVL = 8;
    localparam int DEF_START_LVL   = 9;

endpackage

// File: rtl/level_counter.sv
// Saturating up/down fill counter clamped to [0, DEPTH].
// One-cycle update; no backpressure, clear beats increment beats decrement.
module level_counter #(
    parameter int DEPTH = 10,
    parameter int LW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          i_clr,
    input  logic          i_inc,
    input  logic          i_dec,
    input  logic [LW-1:0] i_up_step,
    input  logic [LW-1:0] i_dn_step,
    output logic [LW-1:0] o_level,
    output logic [LW-1:0] o_up_val,
    output logic [LW-1:0] o_dn_val
);

    localparam logic [LW:0] CEIL = (LW + 1)'(DEPTH);

    logic [LW-1:0] r_level;
    logic [LW:0]   w_sum;
    logic [LW:0]   w_diff;

    // One extra bit catches both overflow past DEPTH and borrow below zero.
    assign w_sum    = {1'b0, r_level} + {1'b0, i_up_step};
    assign w_diff   = {1'b0, r_level} - {1'b0, i_dn_step};
    assign o_up_val = (w_sum > CEIL) ? CEIL[LW-1:0] : w_sum[LW-1:0];
    assign o_dn_val = w_diff[LW] ? '0 : w_diff[LW-1:0];
    assign o_level  = r_level;

    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_level <= '0;
        end else if (i_inc) begin
            r_level <= o_up_val;
        end else if (i_dec) begin
            r_level <= o_dn_val;
        end
    end

endmodule

// File: rtl/scan_buffer_ctrl.sv
// Scan buffer controller: fill on scan, drain on transfer/flush, peer handshake pulses.
// All outputs registered, one edge from qualifying input; no backpressure.
module scan_buffer_ctrl
    import scanner_pkg::*;
#(
    parameter int DEPTH       = DEF_DEPTH,
    parameter int FILL_STEP   = DEF_FILL_STEP,
    parameter int DRAIN_STEP  = DEF_DRAIN_STEP,
    parameter int FLUSH_STEP  = DEF_FLUSH_STEP,
    parameter int STANDBY_LVL = DEF_STANDBY_LVL,
    parameter int START_LVL   = DEF_START_LVL,
    parameter int LW          = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          goToStandby,
    input  logic          startScan,
    input  logic          startTransfer,
    input  logic          flush,
    input  logic          abort,
    output logic [LW-1:0] level,
    output logic [2:0]    state,
    output logic          otherGoToStandby,
    output logic          otherStartScan,
    output logic          otherFlush,
    output logic          done
);

    if (!(STANDBY_LVL >= 1 && STANDBY_LVL <= START_LVL && START_LVL <= DEPTH &&
          FILL_STEP >= 1 && FILL_STEP <= DEPTH && DRAIN_STEP >= 1 && DRAIN_STEP <= DEPTH &&
          FLUSH_STEP >= 1 && FLUSH_STEP <= DEPTH)) begin : g_bad_params
        $error("scan_buffer_ctrl: illegal level/step parameters");
    end

    localparam logic [LW-1:0] FULL_L  = LW'(DEPTH);
    localparam logic [LW-1:0] FILL_L  = LW'(FILL_STEP);
    localparam logic [LW-1:0] DRAIN_L = LW'(DRAIN_STEP);
    localparam logic [LW-1:0] FLUSH_L = LW'(FLUSH_STEP);
    localparam logic [LW-1:0] SB_L    = LW'(STANDBY_LVL);
    localparam logic [LW-1:0] SS_L    = LW'(START_LVL);

    state_e        r_state;
    state_e        w_state_nxt;
    logic          r_sb_p, r_ss_p, r_flush_p, r_done_p;
    logic          w_sb_p, w_ss_p, w_flush_p, w_done_p;
    logic          w_inc, w_dec;
    logic [LW-1:0] w_dn_step;
    logic [LW-1:0] w_level;
    logic [LW-1:0] w_up_val;
    logic [LW-1:0] w_dn_val;

    level_counter #(
        .DEPTH (DEPTH),
        .LW    (LW)
    ) u_level (
        .clk       (clk),
        .i_clr     (reset),
        .i_inc     (w_inc),
        .i_dec     (w_dec),
        .i_up_step (FILL_L),
        .i_dn_step (w_dn_step),
        .o_level   (w_level),
        .o_up_val  (w_up_val),
        .o_dn_val  (w_dn_val)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_inc       = 1'b0;
        w_dec       = 1'b0;
        w_dn_step   = DRAIN_L;
        w_sb_p      = 1'b0;
        w_ss_p      = 1'b0;
        w_flush_p   = 1'b0;
        w_done_p    = 1'b0;
        case (r_state)
            ST_LOW_POWER: if (goToStandby) w_state_nxt = ST_STANDBY;
            ST_STANDBY:   if (startScan)   w_state_nxt = ST_SCANNING;
            ST_SCANNING: begin
                if (abort) begin
                    w_state_nxt = ST_FLUSHING;
                    w_flush_p   = 1'b1;
                end else begin
                    w_inc = 1'b1;
                    // Fill is monotone, so a threshold is crossed exactly once per scan.
                    w_sb_p = (w_level < SB_L) && (w_up_val >= SB_L);
                    w_ss_p = (w_level < SS_L) && (w_up_val >= SS_L);
                    if (w_up_val == FULL_L) w_state_nxt = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (startTransfer) begin
                    w_state_nxt = ST_XFERRING;
                end else if (flush) begin
                    w_state_nxt = ST_FLUSHING;
                    w_flush_p   = 1'b1;
                end
            end
            ST_XFERRING, ST_FLUSHING: begin
                w_dec     = 1'b1;
                w_dn_step = (r_state == ST_FLUSHING) ? FLUSH_L : DRAIN_L;
                if (w_dn_val == '0) begin
                    w_state_nxt = ST_LOW_POWER;
                    w_done_p    = 1'b1;
                end
            end
            default: w_state_nxt = ST_LOW_POWER;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_LOW_POWER;
            r_sb_p    <= 1'b0;
            r_ss_p    <= 1'b0;
            r_flush_p <= 1'b0;
            r_done_p  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_sb_p    <= w_sb_p;
            r_ss_p    <= w_ss_p;
            r_flush_p <= w_flush_p;
            r_done_p  <= w_done_p;
        end
    end

    assign level            = w_level;
    assign state            = r_state;
    assign otherGoToStandby = r_sb_p;
    assign otherStartScan   = r_ss_p;
    assign otherFlush       = r_flush_p;
    assign done             = r_done_p;

endmodule

// File: tb/tb_scan_buffer_ctrl.sv
// Scoreboard bench: two controllers (default and large-step) driven in lockstep against a behavioural model.
module tb_scan_buffer_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic goToStandby = 1'b0, startScan = 1'b0, startTransfer = 1'b0, flush = 1'b0, abort = 1'b0;

    logic [3:0] level_a, level_b;
    logic [2:0] state_a, state_b;
    logic sb_a, ss_a, of_a, dn_a;
    logic sb_b, ss_b, of_b, dn_b;

    int n_chk = 0;
    int n_pass = 0;

    typedef struct {
        int st;
        int lvl;
        bit sb;
        bit ss;
        bit of;
        bit dn;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    // Model configuration per instance: 0 = defaults, 1 = FILL_STEP 4 with lowered thresholds.
    int p_depth[2] = '{10, 10};
    int p_fill[2]  = '{1, 4};
    int p_drain[2] = '{1, 1};
    int p_flush[2] = '{2, 2};
    int p_sbl[2]   = '{8, 6};
    int p_ssl[2]   = '{9, 8};
    int m_st[2]    = '{0, 0};
    int m_lvl[2]   = '{0, 0};

    scan_buffer_ctrl dut_a (
        .clk(clk), .reset(reset), .goToStandby(goToStandby), .startScan(startScan),
        .startTransfer(startTransfer), .flush(flush), .abort(abort),
        .level(level_a), .state(state_a), .otherGoToStandby(sb_a),
        .otherStartScan(ss_a), .otherFlush(of_a), .done(dn_a)
    );

    scan_buffer_ctrl #(.FILL_STEP(4), .STANDBY_LVL(6), .START_LVL(8)) dut_b (
        .clk(clk), .reset(reset), .goToStandby(goToStandby), .startScan(startScan),
        .startTransfer(startTransfer), .flush(flush), .abort(abort),
        .level(level_b), .state(state_b), .otherGoToStandby(sb_b),
        .otherStartScan(ss_b), .otherFlush(of_b), .done(dn_b)
    );

    always #5 clk = ~clk;

    task automatic check_one(input string nm, input int act, input int exp_v);
        n_chk++;
        if (act == exp_v) n_pass++;
        else $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp_v, $time);
    endtask

    // Next outputs from the behavioural rules: fill clamps at depth, drains clamp at zero.
    task automatic model(input int k, input bit rs, g, s, t, f, a);
        exp_t e;
        int cur_st = m_st[k];
        int cur_l  = m_lvl[k];
        e = '{st: cur_st, lvl: cur_l, sb: 0, ss: 0, of: 0, dn: 0};
        if (rs) begin
            e.st = 0;
            e.lvl = 0;
        end else begin
            case (cur_st)
                0: if (g) e.st = 1;
                1: if (s) e.st = 2;
                2: begin
                    if (a) begin
                        e.st = 5;
                        e.of = 1;
                    end else begin
                        e.lvl = (cur_l + p_fill[k] > p_depth[k]) ? p_depth[k] : cur_l + p_fill[k];
                        e.sb  = (cur_l < p_sbl[k]) && (e.lvl >= p_sbl[k]);
                        e.ss  = (cur_l < p_ssl[k]) && (e.lvl >= p_ssl[k]);
                        if (e.lvl == p_depth[k]) e.st = 3;
                    end
                end
                3: begin
                    if (t) e.st = 4;
                    else if (f) begin
                        e.st = 5;
                        e.of = 1;
                    end
                end
                4, 5: begin
                    e.lvl = cur_l - ((cur_st == 4) ? p_drain[k] : p_flush[k]);
                    if (e.lvl < 0) e.lvl = 0;
                    if (e.lvl == 0) begin
                        e.st = 0;
                        e.dn = 1;
                    end
                end
                default: e.st = 0;
            endcase
        end
        m_st[k]  = e.st;
        m_lvl[k] = e.lvl;
        if (k == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    task automatic drive(input bit rs, g, s, t, f, a);
        @(negedge clk);
        reset = rs; goToStandby = g; startScan = s; startTransfer = t; flush = f; abort = a;
        model(0, rs, g, s, t, f, a);
        model(1, rs, g, s, t, f, a);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0);
    endtask

    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            check_one("a.state", int'(state_a), e.st);
            check_one("a.level", int'(level_a), e.lvl);
            check_one("a.otherGoToStandby", int'(sb_a), int'(e.sb));
            check_one("a.otherStartScan", int'(ss_a), int'(e.ss));
            check_one("a.otherFlush", int'(of_a), int'(e.of));
            check_one("a.done", int'(dn_a), int'(e.dn));
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            check_one("b.state", int'(state_b), e.st);
            check_one("b.level", int'(level_b), e.lvl);
            check_one("b.otherGoToStandby", int'(sb_b), int'(e.sb));
            check_one("b.otherStartScan", int'(ss_b), int'(e.ss));
            check_one("b.otherFlush", int'(of_b), int'(e.of));
            check_one("b.done", int'(dn_b), int'(e.dn));
        end
    end

    initial begin
        drive(1, 0, 0, 0, 0, 0);
        drive(1, 1, 1, 1, 1, 1);
        after_edge();
        check_one("reset.state", int'(state_a), 0);
        check_one("reset.level", int'(level_a), 0);

        // Fill, with the large-step instance checked at its double-threshold step.
        drive(0, 1, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 0, 0);
        idle(2);
        after_edge();
        check_one("big.level", int'(level_b), 8);
        check_one("big.both_pulses", int'({sb_b, ss_b}), 3);
        idle(8);
        after_edge();
        check_one("fill.state", int'(state_a), 3);
        check_one("fill.level", int'(level_a), 10);

        // Transfer to empty.
        drive(0, 0, 0, 1, 0, 0);
        idle(10);
        after_edge();
        check_one("xfer.state", int'(state_a), 0);
        check_one("xfer.done", int'(dn_a), 1);
        idle(1);
        after_edge();
        check_one("xfer.done_once", int'(dn_a), 0);

        // Transfer wins over flush, then flush alone.
        drive(0, 1, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 0, 0);
        idle(10);
        drive(0, 0, 0, 1, 1, 0);
        after_edge();
        check_one("both.state", int'(state_a), 4);
        idle(10);
        drive(0, 1, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 0, 0);
        idle(10);
        drive(0, 0, 0, 0, 1, 0);
        after_edge();
        check_one("flush.state", int'(state_a), 5);
        check_one("flush.otherFlush", int'(of_a), 1);
        idle(5);
        after_edge();
        check_one("flush.end", int'(state_a), 0);

        // Abort at level 5.
        drive(0, 1, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 0, 0);
        idle(5);
        drive(0, 0, 0, 0, 0, 1);
        after_edge();
        check_one("abort.state", int'(state_a), 5);
        check_one("abort.level", int'(level_a), 5);
        idle(3);
        after_edge();
        check_one("abort.end", int'(state_a), 0);

        // Reset while transferring at level 6.
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 0, 0);
        idle(10);
        drive(0, 0, 0, 1, 0, 0);
        idle(4);
        after_edge();
        check_one("rstx.level_before", int'(level_a), 6);
        drive(1, 0, 0, 0, 0, 0);
        after_edge();
        check_one("rstx.state", int'(state_a), 0);
        check_one("rstx.level", int'(level_a), 0);
        check_one("rstx.done", int'(dn_a), 0);

        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 63) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0);
        end
        idle(2);
        after_edge();
        check_one("drain.q0", q0.size(), 0);
        check_one("drain.q1", q1.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/scan_buffer_ctrl.md
SCAN_BUFFER_CTRL -- requirements
Module: scan_buffer_ctrl

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset: clock port clk, reset port reset.
REQ-002 The module SHALL take these parameters (name, default, meaning), one per line:
- DEPTH, 10, buffer capacity in units.
- FILL_STEP, 1, units added per scanning cycle.
- DRAIN_STEP, 1, units removed per transfer cycle.
- FLUSH_STEP, 2, units removed per flushing cycle.
- STANDBY_LVL, 8, level that triggers the peer standby request.
- START_LVL, 9, level that triggers the peer scan request.
- LW, $clog2(DEPTH+1), derived level width; not overridden.
REQ-003 The module SHALL have these ports (name, direction, width, meaning), one per line:
- clk, in, 1, clock.
- reset, in, 1, synchronous active-high reset.
- goToStandby, in, 1, leave low power.
- startScan, in, 1, begin filling the buffer.
- startTransfer, in, 1, begin draining to the host.
- flush, in, 1, discard buffer contents.
- abort, in, 1, cancel the scan in progress.
- level, out, LW, current buffer fill in units.
- state, out, 3, current state encoding.
- otherGoToStandby, out, 1, one-cycle pulse to the peer.
- otherStartScan, out, 1, one-cycle pulse to the peer.
- otherFlush, out, 1, one-cycle pulse to the peer.
- done, out, 1, one-cycle pulse when the buffer has emptied.
REQ-004 Elaboration SHALL fail unless 1<=STANDBY_LVL<=START_LVL<=DEPTH and 1<=FILL_STEP, DRAIN_STEP, FLUSH_STEP<=DEPTH.

Function
REQ-005 States SHALL be LOW_POWER=0, STANDBY=1, SCANNING=2, IDLE=3, XFERRING=4, FLUSHING=5; codes 6 and 7 SHALL go to LOW_POWER on the next edge.
REQ-006 LOW_POWER SHALL go to STANDBY when goToStandby=1, and hold otherwise.
REQ-007 STANDBY SHALL go to SCANNING when startScan=1, and hold otherwise.
REQ-008 SCANNING, each cycle:
- level SHALL become min(level+FILL_STEP, DEPTH).
- state SHALL move to IDLE on the same edge at which level becomes DEPTH.
REQ-009 SCANNING with abort=1 SHALL go to FLUSHING, leave level unchanged that cycle and pulse otherFlush; abort SHALL take priority over filling.
REQ-010 IDLE SHALL go to XFERRING on startTransfer=1, else to FLUSHING on flush=1, else hold; startTransfer SHALL win when both are asserted.
REQ-011 XFERRING, each cycle:
- level SHALL become max(level-DRAIN_STEP, 0).
- state SHALL move to LOW_POWER on the edge at which level becomes 0.
REQ-012 FLUSHING SHALL behave as REQ-011 using FLUSH_STEP.
REQ-013 Entering FLUSHING from IDLE SHALL pulse otherFlush.
REQ-014 done SHALL pulse for exactly the first cycle in which state is LOW_POWER after XFERRING or FLUSHING.
REQ-015 Arithmetic SHALL be performed at LW+1 bits; level SHALL never exceed DEPTH and never wrap below 0.
REQ-016 otherGoToStandby SHALL pulse for exactly the first cycle in which level>=STANDBY_LVL during a fill.
REQ-017 otherStartScan SHALL pulse for exactly the first cycle in which level>=START_LVL during a fill.
REQ-018 If one step crosses both thresholds, both pulses SHALL assert in the same cycle.
REQ-019 Each threshold pulse SHALL fire at most once per scan.
REQ-020 Inputs not named for the current state SHALL be ignored.
REQ-021 All outputs SHALL be registered; latency from a qualifying input to the state change SHALL be one edge.

Reset
REQ-022 When reset=1 at an edge, the module SHALL set state=LOW_POWER, level=0 and all pulse outputs to 0, regardless of the current state.
REQ-023 Reset mid-scan or mid-transfer SHALL discard the fill level without asserting done or otherFlush.
REQ-024 Reset SHALL override every other input in the same cycle.

Structure
REQ-025 A shared package scanner_pkg SHALL hold the 3-bit state encoding and the default DEPTH and threshold constants.
REQ-026 Level arithmetic SHALL live in one sub-module, level_counter: parametrised saturating up/down counter with width LW, ceiling DEPTH, separate up and down step inputs, and a clear input.

Verification
REQ-027 The bench SHALL cover these scenarios, defaults unless stated, one per line:
- Fill: reset, goToStandby, startScan -> level counts 1..10 on successive edges; otherGoToStandby pulses when level=8, otherStartScan when level=9; IDLE when level=10.
- Transfer: from IDLE, startTransfer -> level drops by 1 per cycle to 0; then LOW_POWER with one done pulse.
- Flush: from IDLE, flush and startTransfer asserted together -> XFERRING; separate run with flush alone -> FLUSHING; level 10,8,...,0; otherFlush pulses once.
- Abort: abort at level=5 during scan -> FLUSHING at level 5, otherFlush pulse; then 3, 1, 0 and LOW_POWER.
- Large steps: FILL_STEP=4, DEPTH=10 -> levels 4, 8, 10 with saturation; both peer pulses when level=8.
- Reset in XFERRING at level=6 -> next cycle state=LOW_POWER, level=0, no done pulse.
